// File: rtl/fsm_alarm_seq_pkg.sv
// Shared defaults and the lamp input classification type for the alarm sequencer.
package fsm_alarm_seq_pkg;

  localparam int DEF_NUM_LAMPS = 3;
  localparam int DEF_SEQ_LEN   = 3;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_STICKY    = 0;

  typedef enum logic [1:0] {
    IN_NONE,
    IN_ONE,
    IN_MULTI
  } in_class_e;

endpackage

// File: rtl/fsm_alarm_seq_lamp_classifier.sv
// Combinational lamp classifier: no lamp, exactly one lamp (with its index), or several.
module lamp_classifier
  import fsm_alarm_seq_pkg::*;
#(
  parameter int NUM_LAMPS = DEF_NUM_LAMPS,
  parameter int IDX_W     = $clog2(DEF_NUM_LAMPS)
) (
  input  logic [NUM_LAMPS-1:0] lamps,
  output in_class_e            cls,
  output logic [IDX_W-1:0]     idx
);

  logic [3:0] ones;
  logic       found;

  // Count lit lamps and encode the lowest lit lamp's index.
  always_comb begin
    ones  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
      ones = ones + 4'(lamps[i]);
      if (lamps[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    if (ones == 4'd0) begin
      cls = IN_NONE;
    end else if (ones == 4'd1) begin
      cls = IN_ONE;
    end else begin
      cls = IN_MULTI;
    end
  end

endmodule

// File: rtl/fsm_alarm_seq.sv
// Programmable lamp-sequence detector with pulse or sticky alarm and a saturating
// detection counter.
module fsm_alarm_seq
  import fsm_alarm_seq_pkg::*;
#(
  parameter int NUM_LAMPS = DEF_NUM_LAMPS,
  parameter int SEQ_LEN   = DEF_SEQ_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int STICKY    = DEF_STICKY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LAMPS-1:0]           lamps,
  input  logic                           prog_we,
  input  logic [$clog2(SEQ_LEN)-1:0]     prog_idx,
  input  logic [$clog2(NUM_LAMPS)-1:0]   prog_lamp,
  input  logic                           alarm_ack,
  output logic                           alarm_bit,
  output logic [$clog2(SEQ_LEN+1)-1:0]   progress,
  output logic                           err_bit,
  output logic [CNT_W-1:0]               det_count
);

  localparam int IDX_W  = $clog2(SEQ_LEN);
  localparam int LAMP_W = $clog2(NUM_LAMPS);
  localparam int PROG_W = $clog2(SEQ_LEN+1);

  logic [LAMP_W-1:0] seq_q [SEQ_LEN];
  logic [LAMP_W-1:0] seq_d [SEQ_LEN];
  logic [PROG_W-1:0] progress_q, progress_d;
  logic              alarm_q, alarm_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  det_q, det_d;

  in_class_e         cls;
  logic [LAMP_W-1:0] lamp_idx;
  logic [LAMP_W-1:0] cur_entry, prev_entry;
  logic              detect;

  lamp_classifier #(
    .NUM_LAMPS (NUM_LAMPS),
    .IDX_W     (LAMP_W)
  ) u_cls (
    .lamps (lamps),
    .cls   (cls),
    .idx   (lamp_idx)
  );

  // Look up the entry expected next and the one just matched (for repeat tolerance).
  always_comb begin
    cur_entry  = '0;
    prev_entry = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (progress_q == PROG_W'(i))     cur_entry  = seq_q[i];
      if (progress_q == PROG_W'(i + 1)) prev_entry = seq_q[i];
    end
  end

  // Next-state: programming, sequence tracking, alarm and counter update.
  always_comb begin
    seq_d      = seq_q;
    progress_d = progress_q;
    err_d      = 1'b0;
    detect     = 1'b0;
    alarm_d    = 1'b0;
    det_d      = det_q;
    if (prog_we) begin
      // Out-of-range indices match no loop iteration and are dropped.
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
        if (prog_idx == IDX_W'(i)) seq_d[i] = prog_lamp;
      end
      progress_d = '0;
    end else begin
      case (cls)
        IN_MULTI: begin
          progress_d = '0;
          err_d      = 1'b1;
        end
        IN_ONE: begin
          if (lamp_idx == cur_entry) begin
            if (progress_q == PROG_W'(SEQ_LEN - 1)) begin
              detect     = 1'b1;
              progress_d = '0;
            end else begin
              progress_d = progress_q + PROG_W'(1);
            end
          end else if (progress_q != '0 && lamp_idx == prev_entry) begin
            progress_d = progress_q;
          end else if (lamp_idx == seq_q[0]) begin
            progress_d = PROG_W'(1);
          end else begin
            progress_d = '0;
          end
        end
        default: progress_d = progress_q;
      endcase
      if (STICKY != 0) begin
        alarm_d = detect | (alarm_q & ~alarm_ack);
      end else begin
        alarm_d = detect;
      end
      if (detect && det_q != '1) det_d = det_q + CNT_W'(1);
    end
  end

  // State registers; reset restores the default sequence lamp i at entry i.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
        seq_q[i] <= LAMP_W'(i % NUM_LAMPS);
      end
      progress_q <= '0;
      alarm_q    <= 1'b0;
      err_q      <= 1'b0;
      det_q      <= '0;
    end else begin
      seq_q      <= seq_d;
      progress_q <= progress_d;
      alarm_q    <= alarm_d;
      err_q      <= err_d;
      det_q      <= det_d;
    end
  end

  assign alarm_bit = alarm_q;
  assign progress  = progress_q;
  assign err_bit   = err_q;
  assign det_count = det_q;

endmodule

// File: tb/tb_fsm_alarm_seq.sv
// Bench for fsm_alarm_seq: three instances (default, sticky, 2-bit counter) share stimulus.
module tb_fsm_alarm_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lamps;
  logic       prog_we;
  logic [1:0] prog_idx;
  logic [1:0] prog_lamp;
  logic       alarm_ack;

  logic       alarm_w [3];
  logic [1:0] prog_w  [3];
  logic       err_w   [3];
  logic [7:0] det0, det1;
  logic [1:0] det2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_alarm_seq #(.NUM_LAMPS(3), .SEQ_LEN(3), .CNT_W(8), .STICKY(0)) dut0 (
    .clk(clk), .reset(reset), .lamps(lamps), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_lamp(prog_lamp), .alarm_ack(alarm_ack), .alarm_bit(alarm_w[0]),
    .progress(prog_w[0]), .err_bit(err_w[0]), .det_count(det0));

  fsm_alarm_seq #(.NUM_LAMPS(3), .SEQ_LEN(3), .CNT_W(8), .STICKY(1)) dut1 (
    .clk(clk), .reset(reset), .lamps(lamps), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_lamp(prog_lamp), .alarm_ack(alarm_ack), .alarm_bit(alarm_w[1]),
    .progress(prog_w[1]), .err_bit(err_w[1]), .det_count(det1));

  fsm_alarm_seq #(.NUM_LAMPS(3), .SEQ_LEN(3), .CNT_W(2), .STICKY(0)) dut2 (
    .clk(clk), .reset(reset), .lamps(lamps), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_lamp(prog_lamp), .alarm_ack(alarm_ack), .alarm_bit(alarm_w[2]),
    .progress(prog_w[2]), .err_bit(err_w[2]), .det_count(det2));

  // Reference model: one entry per instance.
  int m_seq   [3][3];
  int m_prog  [3];
  int m_alarm [3];
  int m_err   [3];
  int m_det   [3];
  int m_sticky[3] = '{0, 1, 0};
  int m_max   [3] = '{255, 255, 3};

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int det_of(input int j);
    if (j == 0) return int'(det0);
    if (j == 1) return int'(det1);
    return int'(det2);
  endfunction

  task automatic model_update();
    for (int j = 0; j < 3; j++) begin
      if (reset) begin
        for (int i = 0; i < 3; i++) m_seq[j][i] = i;
        m_prog[j] = 0; m_alarm[j] = 0; m_err[j] = 0; m_det[j] = 0;
      end else if (prog_we) begin
        if (prog_idx < 3) m_seq[j][prog_idx] = int'(prog_lamp);
        m_prog[j] = 0; m_alarm[j] = 0; m_err[j] = 0;
      end else begin
        int n, k;
        bit hit;
        n = $countones(lamps);
        k = 0;
        hit = 0;
        m_err[j] = 0;
        if (n > 1) begin
          m_prog[j] = 0;
          m_err[j] = 1;
        end else if (n == 1) begin
          for (int b = 0; b < 3; b++) if (lamps[b]) k = b;
          if (k == m_seq[j][m_prog[j]]) begin
            m_prog[j]++;
            if (m_prog[j] == 3) begin
              m_prog[j] = 0;
              hit = 1;
            end
          end else if (m_prog[j] > 0 && k == m_seq[j][m_prog[j]-1]) begin
            // repeated lamp: stay put
          end else begin
            m_prog[j] = (k == m_seq[j][0]) ? 1 : 0;
          end
        end
        m_alarm[j] = m_sticky[j] != 0 ? int'(hit || (m_alarm[j] != 0 && !alarm_ack)) : int'(hit);
        if (hit && m_det[j] < m_max[j]) m_det[j]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int j = 0; j < 3; j++) begin
      check($sformatf("u%0d.alarm", j), int'(alarm_w[j]), m_alarm[j]);
      check($sformatf("u%0d.progress", j), int'(prog_w[j]), m_prog[j]);
      check($sformatf("u%0d.err", j), int'(err_w[j]), m_err[j]);
      check($sformatf("u%0d.det", j), det_of(j), m_det[j]);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] l, input logic we,
                      input logic [1:0] pi, input logic [1:0] pl, input logic ak);
    reset = r; lamps = l; prog_we = we; prog_idx = pi; prog_lamp = pl; alarm_ack = ak;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic lamp(input logic [2:0] l, input logic ak);
    step(1'b0, l, 1'b0, 2'd0, 2'd0, ak);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] lamps;
    logic       we;
    logic [1:0] pidx;
    logic [1:0] plamp;
    logic       ea;
    int         ep;
    logic       ee;
    int         ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] l, input logic we, input logic [1:0] pi,
                     input logic [1:0] pl, input logic ea, input int ep, input logic ee,
                     input int ed);
    vec_t v;
    v.rst = r; v.lamps = l; v.we = we; v.pidx = pi; v.plamp = pl;
    v.ea = ea; v.ep = ep; v.ee = ee; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; lamps = '0; prog_we = 1'b0; prog_idx = '0; prog_lamp = '0; alarm_ack = 1'b0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) m_seq[j][i] = i;
      m_prog[j] = 0; m_alarm[j] = 0; m_err[j] = 0; m_det[j] = 0;
    end
    #2;

    // Expected values below are for the default (pulse, 8-bit counter) instance.
    //   rst  lamps    we  idx  lamp   alarm prog err det
    add(1, 3'b000, 0, 0, 0,   0, 0, 0, 0);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 0);
    add(0, 3'b010, 0, 0, 0,   0, 2, 0, 0);
    add(0, 3'b100, 0, 0, 0,   1, 0, 0, 1);
    add(0, 3'b000, 0, 0, 0,   0, 0, 0, 1);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 1);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 1);
    add(0, 3'b000, 0, 0, 0,   0, 1, 0, 1);
    add(0, 3'b010, 0, 0, 0,   0, 2, 0, 1);
    add(0, 3'b010, 0, 0, 0,   0, 2, 0, 1);
    add(0, 3'b100, 0, 0, 0,   1, 0, 0, 2);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 2);
    add(0, 3'b100, 0, 0, 0,   0, 0, 0, 2);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 2);
    add(0, 3'b010, 0, 0, 0,   0, 2, 0, 2);
    add(0, 3'b011, 0, 0, 0,   0, 0, 1, 2);
    add(0, 3'b000, 0, 0, 0,   0, 0, 0, 2);
    add(0, 3'b000, 1, 0, 2,   0, 0, 0, 2);
    add(0, 3'b000, 1, 1, 0,   0, 0, 0, 2);
    add(0, 3'b000, 1, 2, 1,   0, 0, 0, 2);
    add(0, 3'b000, 1, 3, 0,   0, 0, 0, 2);
    add(0, 3'b100, 0, 0, 0,   0, 1, 0, 2);
    add(0, 3'b001, 0, 0, 0,   0, 2, 0, 2);
    add(0, 3'b010, 0, 0, 0,   1, 0, 0, 3);
    add(0, 3'b001, 0, 0, 0,   0, 0, 0, 3);
    add(0, 3'b010, 0, 0, 0,   0, 0, 0, 3);
    add(0, 3'b100, 0, 0, 0,   0, 1, 0, 3);
    add(0, 3'b001, 0, 0, 0,   0, 2, 0, 3);
    add(0, 3'b010, 1, 1, 0,   0, 0, 0, 3);
    add(0, 3'b100, 0, 0, 0,   0, 1, 0, 3);
    add(1, 3'b000, 0, 0, 0,   0, 0, 0, 0);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 0);
    add(0, 3'b010, 0, 0, 0,   0, 2, 0, 0);
    add(1, 3'b100, 0, 0, 0,   0, 0, 0, 0);
    add(1, 3'b001, 1, 0, 2,   0, 0, 0, 0);
    add(0, 3'b001, 0, 0, 0,   0, 1, 0, 0);

    for (int t = 0; t < tbl.size(); t++) begin
      step(tbl[t].rst, tbl[t].lamps, tbl[t].we, tbl[t].pidx, tbl[t].plamp, 1'b0);
      check($sformatf("tbl%0d.alarm", t), int'(alarm_w[0]), int'(tbl[t].ea));
      check($sformatf("tbl%0d.progress", t), int'(prog_w[0]), tbl[t].ep);
      check($sformatf("tbl%0d.err", t), int'(err_w[0]), int'(tbl[t].ee));
      check($sformatf("tbl%0d.det", t), int'(det0), tbl[t].ed);
    end

    // Sticky alarm: hold without ack, clear on ack, detection beats a coincident ack.
    step(1'b1, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0);
    lamp(3'b001, 1'b0); lamp(3'b010, 1'b0); lamp(3'b100, 1'b0);
    check("sticky.set", int'(alarm_w[1]), 1);
    for (int c = 0; c < 5; c++) begin
      lamp(3'b000, 1'b0);
      check($sformatf("sticky.hold%0d", c), int'(alarm_w[1]), 1);
    end
    lamp(3'b000, 1'b1);
    check("sticky.ack", int'(alarm_w[1]), 0);
    lamp(3'b001, 1'b0); lamp(3'b010, 1'b0); lamp(3'b100, 1'b1);
    check("sticky.ack_vs_det", int'(alarm_w[1]), 1);
    check("pulse.ack_vs_det", int'(alarm_w[0]), 1);
    lamp(3'b000, 1'b0);
    check("sticky.after", int'(alarm_w[1]), 1);
    check("pulse.after", int'(alarm_w[0]), 0);
    lamp(3'b000, 1'b1);
    check("sticky.ack2", int'(alarm_w[1]), 0);

    // Counter saturation at CNT_W=2, then reset mid-match.
    step(1'b1, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      lamp(3'b001, 1'b0); lamp(3'b010, 1'b0); lamp(3'b100, 1'b0);
    end
    check("sat.det2", int'(det2), 3);
    check("sat.det0", int'(det0), 4);
    lamp(3'b001, 1'b0); lamp(3'b010, 1'b0);
    check("midmatch.progress", int'(prog_w[2]), 2);
    step(1'b1, 3'b100, 1'b0, 2'd0, 2'd0, 1'b0);
    check("midreset.progress", int'(prog_w[2]), 0);
    check("midreset.det", int'(det2), 0);
    check("midreset.alarm", int'(alarm_w[2]), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic       r, we, ak;
      logic [2:0] l;
      logic [1:0] pi, pl;
      int         sel;
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 15) == 0);
      ak = ($urandom_range(0, 3) == 0);
      pi = 2'($urandom_range(0, 3));
      pl = 2'($urandom_range(0, 2));
      sel = $urandom_range(0, 7);
      if (sel < 5)      l = 3'b001 << $urandom_range(0, 2);
      else if (sel < 6) l = 3'b000;
      else              l = 3'($urandom_range(0, 7));
      step(r, l, we, pi, pl, ak);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
